// File: rtl/stack_controller_pkg.sv
// Shared types for the stack controller slice.
//   stack_op_t    : stack micro-op encoding driven by the control unit
//   stack_state_t : sequencer states, one bus step per state
//   STACK_*_DEFAULT : default stack window (lowest push address, empty SP)
package stack_controller_pkg;

  typedef enum logic [1:0] {
    PUSH8 = 2'd0,
    POP8  = 2'd1,
    CALL  = 2'd2,
    RET   = 2'd3
  } stack_op_t;

  typedef enum logic [3:0] {
    IDLE,
    PW,
    PHI,
    PLO,
    INC,
    RD,
    CAP,
    RDL,
    CAPL,
    RDH,
    CAPH,
    DONE
  } stack_state_t;

  localparam logic [15:0] STACK_LIMIT_DEFAULT = 16'h0100;
  localparam logic [15:0] STACK_TOP_DEFAULT   = 16'h01FF;

endpackage

// File: rtl/stack_controller_if.sv
// Bus bundle between control unit, stack controller, SP and RAM port.
//   Control side : start, op, data_in, pc_in -> busy, done, data_out, pc_out
//   SP side      : sp_addr -> sp_inc, sp_dec
//   RAM side     : mem_rdata -> mem_addr, mem_wdata, mem_we, mem_re
//   error        : present only when STACK_BOUNDS_CHECK_EN is defined
// Modport slave is the controller's view; master is the surrounding logic.
interface stack_controller_if;

  logic                            start;
  stack_controller_pkg::stack_op_t op;
  logic [7:0]                      data_in;
  logic [15:0]                     pc_in;
  logic                            busy;
  logic                            done;
  logic [7:0]                      data_out;
  logic [15:0]                     pc_out;
  logic [15:0]                     sp_addr;
  logic                            sp_inc;
  logic                            sp_dec;
  logic [15:0]                     mem_addr;
  logic [7:0]                      mem_wdata;
  logic                            mem_we;
  logic                            mem_re;
  logic [7:0]                      mem_rdata;
`ifdef STACK_BOUNDS_CHECK_EN
  logic                            error;
`endif

  modport slave (
    input  start, op, data_in, pc_in, sp_addr, mem_rdata,
    output busy, done, data_out, pc_out, sp_inc, sp_dec,
           mem_addr, mem_wdata, mem_we, mem_re
`ifdef STACK_BOUNDS_CHECK_EN
    , output error
`endif
  );

  modport master (
    output start, op, data_in, pc_in, sp_addr, mem_rdata,
    input  busy, done, data_out, pc_out, sp_inc, sp_dec,
           mem_addr, mem_wdata, mem_we, mem_re
`ifdef STACK_BOUNDS_CHECK_EN
    , input error
`endif
  );

endinterface

// File: rtl/stack_controller_bounds_check.sv
// Combinational stack window check for a requested op at the current SP.
// Only built with STACK_BOUNDS_CHECK_EN defined.
//   op        : requested stack op
//   sp_addr   : SP value at acceptance
//   violation : 1 when the op would leave the [STACK_LIMIT, STACK_TOP] window
`ifdef STACK_BOUNDS_CHECK_EN
module stack_bounds_check
  import stack_controller_pkg::*;
#(
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT,
  parameter logic [15:0] STACK_TOP   = STACK_TOP_DEFAULT
) (
  input  stack_op_t   op,
  input  logic [15:0] sp_addr,
  output logic        violation
);

  always_comb begin
    violation = 1'b0;
    case (op)
      PUSH8:   violation = (sp_addr < STACK_LIMIT);
      CALL:    violation = (sp_addr < (STACK_LIMIT + 16'd1));
      POP8:    violation = (sp_addr > (STACK_TOP - 16'd1));
      RET:     violation = (sp_addr > (STACK_TOP - 16'd2));
      default: violation = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/stack_controller.sv
// Stack micro-op sequencer: turns PUSH8/POP8/CALL/RET into RAM cycles and
// SP strobes. Empty-descending stack: push writes at SP then decrements,
// pop increments then reads.
//   clk, reset : clock, synchronous active-low reset
//   bus        : stack_controller_if.slave (control, SP and RAM signals)
// Optional: STACK_BOUNDS_CHECK_EN adds the sticky `error` output and the
// window check; without it SP arithmetic wraps silently.
module stack_controller
  import stack_controller_pkg::*;
`ifdef STACK_BOUNDS_CHECK_EN
#(
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT,
  parameter logic [15:0] STACK_TOP   = STACK_TOP_DEFAULT
)
`endif
(
  input logic               clk,
  input logic               reset,
  stack_controller_if.slave bus
);

  stack_state_t state;
  stack_op_t    op_q;
  logic [7:0]   pc_lo_q;
  logic [7:0]   rd_lo_q;
  logic         busy_q;
  logic         done_q;
  logic [7:0]   data_out_q;
  logic [15:0]  pc_out_q;
  logic         sp_inc_q;
  logic         sp_dec_q;
  logic         mem_we_q;
  logic         mem_re_q;
  logic [7:0]   mem_wdata_q;
  logic         addr_en_q;
  logic         reject;

`ifdef STACK_BOUNDS_CHECK_EN
  logic error_q;

  stack_bounds_check #(
    .STACK_LIMIT(STACK_LIMIT),
    .STACK_TOP  (STACK_TOP)
  ) u_bounds (
    .op       (bus.op),
    .sp_addr  (bus.sp_addr),
    .violation(reject)
  );

  assign bus.error = error_q;
`else
  assign reject = 1'b0;
`endif

  // Strobes are registered one state ahead; the RAM address follows the live
  // SP so PLO/RD/RDH see the value already moved by the previous strobe.
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_out  = data_out_q;
  assign bus.pc_out    = pc_out_q;
  assign bus.sp_inc    = sp_inc_q;
  assign bus.sp_dec    = sp_dec_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = addr_en_q ? bus.sp_addr : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= PUSH8;
      pc_lo_q     <= '0;
      rd_lo_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      pc_out_q    <= '0;
      sp_inc_q    <= 1'b0;
      sp_dec_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      addr_en_q   <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
      error_q     <= 1'b0;
`endif
    end else begin
      sp_inc_q    <= 1'b0;
      sp_dec_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      addr_en_q   <= 1'b0;
      done_q      <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            pc_lo_q <= bus.pc_in[7:0];
            busy_q  <= 1'b1;
`ifdef STACK_BOUNDS_CHECK_EN
            error_q <= reject;
`endif
            if (reject) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              case (bus.op)
                PUSH8: begin
                  state       <= PW;
                  mem_we_q    <= 1'b1;
                  sp_dec_q    <= 1'b1;
                  addr_en_q   <= 1'b1;
                  mem_wdata_q <= bus.data_in;
                end
                CALL: begin
                  state       <= PHI;
                  mem_we_q    <= 1'b1;
                  sp_dec_q    <= 1'b1;
                  addr_en_q   <= 1'b1;
                  mem_wdata_q <= bus.pc_in[15:8];
                end
                default: begin
                  state    <= INC;
                  sp_inc_q <= 1'b1;
                end
              endcase
            end
          end
        end

        PHI: begin
          state       <= PLO;
          mem_we_q    <= 1'b1;
          sp_dec_q    <= 1'b1;
          addr_en_q   <= 1'b1;
          mem_wdata_q <= pc_lo_q;
        end

        PW, PLO: begin
          state  <= DONE;
          done_q <= 1'b1;
        end

        INC: begin
          state     <= (op_q == POP8) ? RD : RDL;
          mem_re_q  <= 1'b1;
          addr_en_q <= 1'b1;
        end

        RD: state <= CAP;

        CAP: begin
          data_out_q <= bus.mem_rdata;
          state      <= DONE;
          done_q     <= 1'b1;
        end

        RDL: begin
          state    <= CAPL;
          sp_inc_q <= 1'b1;
        end

        // Low byte is parked so pc_out changes only when the whole RET lands.
        CAPL: begin
          rd_lo_q   <= bus.mem_rdata;
          state     <= RDH;
          mem_re_q  <= 1'b1;
          addr_en_q <= 1'b1;
        end

        RDH: state <= CAPH;

        CAPH: begin
          pc_out_q <= {bus.mem_rdata, rd_lo_q};
          state    <= DONE;
          done_q   <= 1'b1;
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
module tb_stack_controller;
  import stack_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_controller_if bus();

  stack_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // SP and RAM models
  logic [15:0] sp;
  logic        sp_set;
  logic [15:0] sp_set_val;
  logic [7:0]  mem [0:65535];

  assign bus.sp_addr = sp;

  always @(posedge clk) begin
    if (sp_set) sp <= sp_set_val;
    else if (bus.sp_inc) sp <= sp + 16'd1;
    else if (bus.sp_dec) sp <= sp - 16'd1;
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          lat;
    int          n_inc, n_dec, n_we, n_re;
    logic [15:0] wa0;
    logic [7:0]  wd0;
    logic [15:0] wa1;
    logic [7:0]  wd1;
    logic [15:0] ra0;
    logic [7:0]  dout;
    logic [15:0] pout;
    logic [15:0] sp;
    logic        err;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(string nm, int lat, int ni, int nd, int nw, int nr,
                              logic [15:0] wa0, logic [7:0] wd0,
                              logic [15:0] wa1, logic [7:0] wd1,
                              logic [15:0] ra0, logic [7:0] dout,
                              logic [15:0] pout, logic [15:0] spv, logic err);
    exp_t e;
    e.name = nm; e.lat = lat;
    e.n_inc = ni; e.n_dec = nd; e.n_we = nw; e.n_re = nr;
    e.wa0 = wa0; e.wd0 = wd0; e.wa1 = wa1; e.wd1 = wd1; e.ra0 = ra0;
    e.dout = dout; e.pout = pout; e.sp = spv; e.err = err;
    return e;
  endfunction

  // Monitor: gathers per-op bus activity, compares on each done pulse
  bit          in_op = 1'b0;
  int          cyc, m_inc, m_dec, m_we, m_re, mutex_bad;
  int          idle_bad = 0;
  logic [15:0] m_wa [2];
  logic [7:0]  m_wd [2];
  logic [15:0] m_ra0;

  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      in_op = 1'b0;
    end else begin
      if (!in_op && bus.busy) begin
        in_op = 1'b1; cyc = 0; m_inc = 0; m_dec = 0; m_we = 0; m_re = 0;
        mutex_bad = 0; m_wa[0] = '0; m_wa[1] = '0; m_wd[0] = '0; m_wd[1] = '0;
        m_ra0 = '0;
      end
      if (!bus.busy) begin
        in_op = 1'b0;
        if (bus.mem_addr != 16'h0 || bus.mem_wdata != 8'h0 || bus.mem_we ||
            bus.mem_re || bus.sp_inc || bus.sp_dec)
          idle_bad++;
      end
      if (in_op) begin
        cyc++;
        if (bus.sp_inc) m_inc++;
        if (bus.sp_dec) m_dec++;
        if (bus.mem_we) begin
          if (m_we < 2) begin
            m_wa[m_we] = bus.mem_addr;
            m_wd[m_we] = bus.mem_wdata;
          end
          m_we++;
        end
        if (bus.mem_re) begin
          if (m_re == 0) m_ra0 = bus.mem_addr;
          m_re++;
        end
        if ((bus.sp_inc && bus.sp_dec) || (bus.mem_we && bus.mem_re)) mutex_bad++;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk({e.name, "/latency"}, cyc, e.lat);
          chk({e.name, "/sp_inc_cnt"}, m_inc, e.n_inc);
          chk({e.name, "/sp_dec_cnt"}, m_dec, e.n_dec);
          chk({e.name, "/we_cnt"}, m_we, e.n_we);
          chk({e.name, "/re_cnt"}, m_re, e.n_re);
          if (e.n_we > 0) begin
            chk({e.name, "/wr0_addr"}, m_wa[0], e.wa0);
            chk({e.name, "/wr0_data"}, m_wd[0], e.wd0);
          end
          if (e.n_we > 1) begin
            chk({e.name, "/wr1_addr"}, m_wa[1], e.wa1);
            chk({e.name, "/wr1_data"}, m_wd[1], e.wd1);
          end
          if (e.n_re > 0) chk({e.name, "/rd0_addr"}, m_ra0, e.ra0);
          chk({e.name, "/data_out"}, bus.data_out, e.dout);
          chk({e.name, "/pc_out"}, bus.pc_out, e.pout);
          chk({e.name, "/sp"}, sp, e.sp);
          chk({e.name, "/strobe_excl"}, mutex_bad, 0);
          chk({e.name, "/idle_bus"}, idle_bad, 0);
`ifdef STACK_BOUNDS_CHECK_EN
          chk({e.name, "/error"}, bus.error, e.err);
`endif
          idle_bad = 0;
        end
      end
    end
  end

  task automatic set_sp(logic [15:0] v);
    @(negedge clk);
    sp_set = 1'b1;
    sp_set_val = v;
    @(posedge clk);
    #1 sp_set = 1'b0;
  endtask

  task automatic do_op(stack_op_t o, logic [7:0] d, logic [15:0] p, exp_t e, bit mid_start);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.data_in = d; bus.pc_in = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // scramble operands: the accepted values must already be latched
    bus.start = 1'b0; bus.data_in = ~d; bus.pc_in = ~p;
    bus.op = (o == PUSH8) ? POP8 : PUSH8;
    if (mid_start) begin
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    if (sb.size() != 0) begin
      chk({e.name, "/done_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.start = 1'b1; bus.op = PUSH8; bus.data_in = 8'hFF; bus.pc_in = 16'hFFFF;
    sp_set = 1'b1; sp_set_val = 16'h01FF;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst/busy", bus.busy, 0);
      chk("rst/done", bus.done, 0);
      chk("rst/sp_inc", bus.sp_inc, 0);
      chk("rst/sp_dec", bus.sp_dec, 0);
      chk("rst/mem_we", bus.mem_we, 0);
      chk("rst/mem_re", bus.mem_re, 0);
      chk("rst/data_out", bus.data_out, 0);
      chk("rst/pc_out", bus.pc_out, 0);
    end
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b0; sp_set = 1'b0;
    repeat (2) @(posedge clk);

    //            name      lat inc dec we re wa0     wd0    wa1     wd1    ra0     dout   pout      sp       err
    do_op(PUSH8, 8'hA5, 16'h0,
          mk("push_a5", 2, 0, 1, 1, 0, 16'h01FF, 8'hA5, 16'h0, 8'h0, 16'h0, 8'h00, 16'h0000, 16'h01FE, 0), 0);
    do_op(POP8, 8'h00, 16'h0,
          mk("pop_a5", 4, 1, 0, 0, 1, 16'h0, 8'h0, 16'h0, 8'h0, 16'h01FF, 8'hA5, 16'h0000, 16'h01FF, 0), 0);
    do_op(PUSH8, 8'h3C, 16'h0,
          mk("push_3c", 2, 0, 1, 1, 0, 16'h01FF, 8'h3C, 16'h0, 8'h0, 16'h0, 8'hA5, 16'h0000, 16'h01FE, 0), 0);
    do_op(POP8, 8'h00, 16'h0,
          mk("pop_3c_midstart", 4, 1, 0, 0, 1, 16'h0, 8'h0, 16'h0, 8'h0, 16'h01FF, 8'h3C, 16'h0000, 16'h01FF, 0), 1);
    do_op(CALL, 8'h00, 16'h1234,
          mk("call_1234", 3, 0, 2, 2, 0, 16'h01FF, 8'h12, 16'h01FE, 8'h34, 16'h0, 8'h3C, 16'h0000, 16'h01FD, 0), 0);
    do_op(RET, 8'h00, 16'h0,
          mk("ret_1234", 6, 2, 0, 0, 2, 16'h0, 8'h0, 16'h0, 8'h0, 16'h01FE, 8'h3C, 16'h1234, 16'h01FF, 0), 0);

`ifdef STACK_BOUNDS_CHECK_EN
    do_op(POP8, 8'h00, 16'h0,
          mk("pop_empty", 1, 0, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0, 8'h3C, 16'h1234, 16'h01FF, 1), 0);
    set_sp(16'h01FE);
    do_op(RET, 8'h00, 16'h0,
          mk("ret_one_byte", 1, 0, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0, 8'h3C, 16'h1234, 16'h01FE, 1), 0);
    do_op(POP8, 8'h00, 16'h0,
          mk("pop_last_ok", 4, 1, 0, 0, 1, 16'h0, 8'h0, 16'h0, 8'h0, 16'h01FF, 8'h12, 16'h1234, 16'h01FF, 0), 0);
    set_sp(16'h00FF);
    do_op(PUSH8, 8'h77, 16'h0,
          mk("push_full", 1, 0, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0, 8'h12, 16'h1234, 16'h00FF, 1), 0);
    set_sp(16'h0100);
    do_op(CALL, 8'h00, 16'hBEEF,
          mk("call_one_slot", 1, 0, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0, 8'h12, 16'h1234, 16'h0100, 1), 0);
    do_op(PUSH8, 8'h77, 16'h0,
          mk("push_limit_ok", 2, 0, 1, 1, 0, 16'h0100, 8'h77, 16'h0, 8'h0, 16'h0, 8'h12, 16'h1234, 16'h00FF, 0), 0);
`else
    set_sp(16'h0000);
    do_op(PUSH8, 8'h5A, 16'h0,
          mk("push_wrap", 2, 0, 1, 1, 0, 16'h0000, 8'h5A, 16'h0, 8'h0, 16'h0, 8'h3C, 16'h1234, 16'hFFFF, 0), 0);
    do_op(POP8, 8'h00, 16'h0,
          mk("pop_wrap", 4, 1, 0, 0, 1, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0000, 8'h5A, 16'h1234, 16'h0000, 0), 0);
`endif

    // reset landing in PLO of a CALL
    set_sp(16'h01FF);
    @(negedge clk);
    bus.start = 1'b1; bus.op = CALL; bus.pc_in = 16'hABCD;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstcall/plo_we", bus.mem_we, 1);
    chk("rstcall/plo_addr", bus.mem_addr, 16'h01FE);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rstcall/busy", bus.busy, 0);
    chk("rstcall/mem_we", bus.mem_we, 0);
    chk("rstcall/sp_dec", bus.sp_dec, 0);
    chk("rstcall/done", bus.done, 0);
    @(posedge clk);
    #1;
    chk("rstcall/mem_we_hold", bus.mem_we, 0);
    chk("rstcall/data_out", bus.data_out, 0);
    chk("rstcall/pc_out", bus.pc_out, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstcall/idle_after", bus.busy, 0);
    chk("rstcall/no_done_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
